// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_ctrl_pkg
//  Purpose  : Shared types and helpers for the program-counter sequencer:
//             FSM state encodings, default datapath width and the next-PC
//             function (pc, imm, taken -> target).
//  Revision : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

  localparam int unsigned PC_XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } pc_state_e;

  // Branch targets are half-word scaled; the shift drops the imm MSB, which
  // is harmless because all PC arithmetic wraps modulo 2^PC_XLEN.
  function automatic logic [PC_XLEN-1:0] pc_next_fn(
    input logic [PC_XLEN-1:0] pc,
    input logic [PC_XLEN-1:0] imm,
    input logic               taken
  );
    return taken ? (pc + (imm << 1)) : (pc + PC_XLEN'(4));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_calc
//  Purpose  : Combinational next-PC generator (sequential or branch target)
//             with misalignment detection. Reusable by a pipelined core.
//  Ports    : pc_i           - current PC
//             branch_imm_i   - sign-extended, unshifted branch immediate
//             branch_taken_i - select branch target instead of pc+4
//             next_o         - selected next PC (unmasked)
//             pc_plus4_o     - pc_i + 4
//             misaligned_o   - next_o[1:0] != 0
//  Revision : 1.0 - initial release
// ============================================================================
module pc_next_calc
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = PC_XLEN
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] branch_imm_i,
  input  logic            branch_taken_i,
  output logic [XLEN-1:0] next_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misaligned_o
);

  assign pc_plus4_o = pc_i + XLEN'(4);

  // The package helper is fixed at the default width; other widths use an
  // equivalent inline expression.
  generate
    if (XLEN == PC_XLEN) begin : g_pkg_fn
      assign next_o = pc_next_fn(pc_i, branch_imm_i, branch_taken_i);
    end else begin : g_generic
      assign next_o = branch_taken_i ? (pc_i + (branch_imm_i << 1)) : pc_plus4_o;
    end
  endgenerate

  assign misaligned_o = (next_o[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : Multi-cycle sequencer owning the program counter of a
//             non-pipelined RISC-V core: fetches over a req/ack handshake,
//             holds the instruction during execute, then commits next PC.
//  Ports    : clk_i/reset_i          - clock, asynchronous active-high reset
//             imem_req_o/addr_o      - fetch request and address (= pc)
//             imem_ack_i/rdata_i     - fetch response
//             instr_o/instr_valid_o  - latched instruction, first-EXEC pulse
//             exec_done_i            - commit strobe from the datapath
//             branch_taken_i/imm_i   - branch select and immediate
//             halt_i                 - enter HALT after this commit
//             pc_o/pc_plus4_o        - architectural PC and PC+4
//             state_o                - FSM state (IDLE/FETCH/EXEC/HALT)
//             retired_o              - committed instruction count
//             fault_o/fault_pc_o     - sticky misaligned-target flag/address
//  Config   : PC_MISALIGN_TRAP_EN - misaligned targets redirect to
//             TRAP_VECTOR and raise fault; otherwise the target is
//             silently word-aligned and fault outputs are tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_o,
  output logic            instr_valid_o,
  input  logic            exec_done_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_imm_i,
  input  logic            halt_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [1:0]      state_o,
  output logic [XLEN-1:0] retired_o,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_pc_o
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] retired_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            imem_req_q;

  logic [XLEN-1:0] w_next;
  logic            w_misaligned;
  logic            w_commit;

  pc_next_calc #(
    .XLEN (XLEN)
  ) u_next (
    .pc_i           (pc_q),
    .branch_imm_i   (branch_imm_i),
    .branch_taken_i (branch_taken_i),
    .next_o         (w_next),
    .pc_plus4_o     (pc_plus4_o),
    .misaligned_o   (w_misaligned)
  );

  assign w_commit = (state_q == S_EXEC) && exec_done_i;

`ifdef PC_MISALIGN_TRAP_EN
  logic            fault_q;
  logic [XLEN-1:0] fault_pc_q;

  assign pc_d = w_misaligned ? TRAP_VECTOR : w_next;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (w_commit && w_misaligned) begin
      fault_q    <= 1'b1;
      fault_pc_q <= w_next;
    end
  end

  assign fault_o    = fault_q;
  assign fault_pc_o = fault_pc_q;
`else
  logic w_unused_trap;

  // Only a taken branch can misalign; drop the low bits to stay word-aligned.
  assign pc_d          = {w_next[XLEN-1:2], 2'b00};
  assign fault_o       = 1'b0;
  assign fault_pc_o    = '0;
  assign w_unused_trap = ^{w_misaligned, TRAP_VECTOR};
`endif

  // Main sequencer. imem_req is a registered output that is high exactly
  // while the FSM sits in FETCH, so the request and address are glitch-free.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      imem_req_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack_i) begin
            instr_q       <= imem_rdata_i;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_commit) begin
            pc_q      <= pc_d;
            retired_q <= retired_q + XLEN'(1);
            if (halt_i) begin
              state_q <= S_HALT;
            end else begin
              state_q    <= S_FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          imem_req_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign state_o       = state_q;
  assign retired_o     = retired_q;

endmodule
`default_nettype wire
